// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state_o
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS sequencer: Moore FSM driving datapath enables and mux selects,
// stalling FETCH/MEMRD/MEMWR on the memory-ready handshake.
module mc_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic             clk,
  input logic             reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0010;
  localparam logic [3:0] AluAnd = 4'b0100;
  localparam logic [3:0] AluOr  = 4'b0101;
  localparam logic [3:0] AluSlt = 4'b1010;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q, state_d;
  logic   rdy;
  logic   pcen, iord, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;

  assign rdy = bus.mem_ready | ~MEM_WAIT_EN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcen       = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = AluAdd;
    illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = rdy;
        pcen    = rdy;
        if (rdy) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is precomputed here into ALUOut.
        alusrcb = 2'b11;
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord = 1'b1;
        if (rdy) state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (rdy) state_d = StFetch;
      end
      StExecute: begin
        alusrca = 1'b1;
        state_d = StAluWb;
        case (bus.funct)
          6'b100000: alucontrol = AluAdd;
          6'b100010: alucontrol = AluSub;
          6'b100100: alucontrol = AluAnd;
          6'b100101: alucontrol = AluOr;
          6'b101010: alucontrol = AluSlt;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        alusrca    = 1'b1;
        alucontrol = AluSub;
        pcsrc      = 2'b01;
        pcen       = bus.zero;
        state_d    = StFetch;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // While reset is held the state already reads FETCH, but its outputs must stay quiet.
    if (reset) begin
      pcen       = 1'b0;
      irwrite    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = AluAdd;
      illegal    = 1'b0;
    end
  end

  assign bus.pcen       = pcen;
  assign bus.iord       = iord;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = illegal;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class and compares
// state and the full packed output word against hand-computed vectors.
module tb_mc_controller;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mc_controller_if bus ();

  mc_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcen, iord, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca,
  //  alusrcb[1:0], pcsrc[1:0], alucontrol[3:0], illegal}
  logic [16:0] outs;
  assign outs = {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst,
                 bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
                 bus.illegal};

  localparam logic [16:0] OFetch   = 17'b10010000_01_00_0000_0;
  localparam logic [16:0] OFetchSt = 17'b00000000_01_00_0000_0;
  localparam logic [16:0] ODecode  = 17'b00000000_11_00_0000_0;
  localparam logic [16:0] ODecIll  = 17'b00000000_11_00_0000_1;
  localparam logic [16:0] OMemAdr  = 17'b00000001_10_00_0000_0;
  localparam logic [16:0] OMemRd   = 17'b01000000_00_00_0000_0;
  localparam logic [16:0] OMemWb   = 17'b00001010_00_00_0000_0;
  localparam logic [16:0] OMemWr   = 17'b01100000_00_00_0000_0;
  localparam logic [16:0] OExSlt   = 17'b00000001_00_00_1010_0;
  localparam logic [16:0] OExSub   = 17'b00000001_00_00_0010_0;
  localparam logic [16:0] OExIll   = 17'b00000001_00_00_0000_1;
  localparam logic [16:0] OAluWb   = 17'b00000110_00_00_0000_0;
  localparam logic [16:0] OBrTaken = 17'b10000001_00_01_0010_0;
  localparam logic [16:0] OBrNot   = 17'b00000001_00_01_0010_0;
  localparam logic [16:0] OAddiEx  = 17'b00000001_10_00_0000_0;
  localparam logic [16:0] OAddiWb  = 17'b00000010_00_00_0000_0;
  localparam logic [16:0] OJump    = 17'b10000000_00_10_0000_0;
  localparam logic [16:0] OQuiet   = 17'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are compared 1 ns later.
  task automatic step(input string tag, input logic [3:0] st, input logic [16:0] o);
    #1;
    check_eq({tag, "_state"}, {28'd0, bus.state_o}, {28'd0, st});
    check_eq({tag, "_outs"}, {15'd0, outs}, {15'd0, o});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.op        = 6'b0;
    bus.funct     = 6'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_state", {28'd0, bus.state_o}, 32'd0);
    check_eq("rst_outs", {15'd0, outs}, {15'd0, OQuiet});
    reset = 1'b0;

    // lw, no stalls: 0,1,2,3,4,0
    bus.op = 6'b100011;
    step("lw_f", 4'd0, OFetch);
    step("lw_d", 4'd1, ODecode);
    step("lw_a", 4'd2, OMemAdr);
    step("lw_r", 4'd3, OMemRd);
    step("lw_wb", 4'd4, OMemWb);

    // lw with a FETCH stall and a MEMRD stall
    bus.mem_ready = 1'b0;
    step("lws_f0", 4'd0, OFetchSt);
    bus.mem_ready = 1'b1;
    step("lws_f1", 4'd0, OFetch);
    step("lws_d", 4'd1, ODecode);
    step("lws_a", 4'd2, OMemAdr);
    bus.mem_ready = 1'b0;
    step("lws_r0", 4'd3, OMemRd);
    bus.mem_ready = 1'b1;
    step("lws_r1", 4'd3, OMemRd);
    step("lws_wb", 4'd4, OMemWb);

    // sw with mem_ready low for 3 MEMWR cycles
    bus.op = 6'b101011;
    step("sw_f", 4'd0, OFetch);
    step("sw_d", 4'd1, ODecode);
    step("sw_a", 4'd2, OMemAdr);
    bus.mem_ready = 1'b0;
    step("sw_w0", 4'd5, OMemWr);
    step("sw_w1", 4'd5, OMemWr);
    step("sw_w2", 4'd5, OMemWr);
    bus.mem_ready = 1'b1;
    step("sw_w3", 4'd5, OMemWr);

    // R-type slt; mem_ready low outside memory states must not stall
    bus.op    = 6'b000000;
    bus.funct = 6'b101010;
    step("slt_f", 4'd0, OFetch);
    bus.mem_ready = 1'b0;
    step("slt_d", 4'd1, ODecode);
    step("slt_e", 4'd6, OExSlt);
    step("slt_wb", 4'd7, OAluWb);
    bus.mem_ready = 1'b1;

    bus.funct = 6'b100010;
    step("sub_f", 4'd0, OFetch);
    step("sub_d", 4'd1, ODecode);
    step("sub_e", 4'd6, OExSub);
    step("sub_wb", 4'd7, OAluWb);

    // unknown funct: illegal in EXECUTE, back to FETCH after 3 cycles
    bus.funct = 6'b000111;
    step("badf_f", 4'd0, OFetch);
    step("badf_d", 4'd1, ODecode);
    step("badf_e", 4'd6, OExIll);

    // beq taken / not taken
    bus.op   = 6'b000100;
    bus.zero = 1'b1;
    step("beq1_f", 4'd0, OFetch);
    step("beq1_d", 4'd1, ODecode);
    step("beq1_b", 4'd8, OBrTaken);
    bus.zero = 1'b0;
    step("beq0_f", 4'd0, OFetch);
    step("beq0_d", 4'd1, ODecode);
    step("beq0_b", 4'd8, OBrNot);

    // addi
    bus.op = 6'b001000;
    step("addi_f", 4'd0, OFetch);
    step("addi_d", 4'd1, ODecode);
    step("addi_e", 4'd9, OAddiEx);
    step("addi_wb", 4'd10, OAddiWb);

    // j
    bus.op = 6'b000010;
    step("j_f", 4'd0, OFetch);
    step("j_d", 4'd1, ODecode);
    step("j_j", 4'd11, OJump);

    // illegal op
    bus.op = 6'b111111;
    step("ill_f", 4'd0, OFetch);
    step("ill_d", 4'd1, ODecIll);
    step("ill_back", 4'd0, OFetch);

    // reset mid-MEMWR
    bus.op = 6'b101011;
    step("rsw_d", 4'd1, ODecode);
    step("rsw_a", 4'd2, OMemAdr);
    bus.mem_ready = 1'b0;
    #1;
    check_eq("rsw_wr_pre", {31'd0, bus.memwrite}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rsw_rst_state", {28'd0, bus.state_o}, 32'd0);
    check_eq("rsw_rst_outs", {15'd0, outs}, {15'd0, OQuiet});
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rsw_hold_outs", {15'd0, outs}, {15'd0, OQuiet});
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    step("rsw_f", 4'd0, OFetch);
    step("rsw_d2", 4'd1, ODecode);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
